// File: rtl/systolic_a_skew_feeder.sv
// A-operand skew feeder for the systolic array: holds a DIM x DIM tile and streams
// it diagonally, lane i lagging lane 0 by i steps, then drains with zeros.

module systolic_a_skew_lane #(
  parameter int BITS_AB  = 8,
  parameter int DIM      = 8,
  parameter int LANE     = 0,
  parameter int ROW_BITS = $clog2(DIM),
  parameter int CNT_BITS = $clog2(2*DIM)
) (
  input  logic [DIM-1:0][BITS_AB-1:0] row_i,
  input  logic [CNT_BITS-1:0]         k_i,
  output logic [BITS_AB-1:0]          elem_o
);
  localparam logic [CNT_BITS-1:0] LANE_K = CNT_BITS'(LANE);
  localparam logic [CNT_BITS-1:0] DIM_K  = CNT_BITS'(DIM);

  logic [CNT_BITS-1:0] col;

  // Column k-i is live only inside the diagonal band; outside it the lane feeds zeros.
  always_comb begin
    col    = k_i - LANE_K;
    elem_o = '0;
    if ((k_i >= LANE_K) && (col < DIM_K)) elem_o = row_i[col[ROW_BITS-1:0]];
  end
endmodule

module systolic_a_skew_feeder #(
  parameter int BITS_AB  = 8,
  parameter int DIM      = 8,
  parameter int ROW_BITS = $clog2(DIM),
  parameter int CNT_BITS = $clog2(2*DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     WrEn,
  input  logic [ROW_BITS-1:0]      Arow,
  input  logic [DIM*BITS_AB-1:0]   Ain,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic                     done
);
  localparam logic [CNT_BITS-1:0] KMAX = CNT_BITS'(2*DIM-1);

  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] mem_q, mem_d;
  logic [DIM-1:0][BITS_AB-1:0]          aout_q, aout_d, lane_val;
  logic [CNT_BITS-1:0]                  k_q, k_d;
  logic                                 done_q, done_d;

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    systolic_a_skew_lane #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .LANE    (i),
      .ROW_BITS(ROW_BITS),
      .CNT_BITS(CNT_BITS)
    ) u_lane (
      .row_i (mem_q[i]),
      .k_i   (k_q),
      .elem_o(lane_val[i])
    );
  end

  // A write always wins over a step and rewinds the stream to k=0.
  always_comb begin
    mem_d  = mem_q;
    aout_d = aout_q;
    k_d    = k_q;
    done_d = done_q;
    if (WrEn) begin
      if (int'(Arow) < DIM) mem_d[Arow] = Ain;
      k_d    = '0;
      done_d = 1'b0;
    end else if (en) begin
      aout_d = lane_val;
      if (k_q != KMAX) k_d = k_q + 1'b1;
      done_d = (k_d == KMAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      aout_q <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      aout_q <= aout_d;
      k_q    <= k_d;
      done_q <= done_d;
    end
  end

  assign Aout = aout_q;
  assign done = done_q;
endmodule

// File: tb/tb_systolic_a_skew_feeder.sv
// Directed bench for systolic_a_skew_feeder: DIM=4 table-driven stream plus
// hand sequences for async reset and the DIM=3 out-of-range row write.

module tb_systolic_a_skew_feeder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, wr;
  logic [1:0]  arow;
  logic [31:0] ain, aout;
  logic        done;

  logic        en3, wr3;
  logic [1:0]  arow3;
  logic [23:0] ain3, aout3;
  logic        done3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_a_skew_feeder #(.BITS_AB(8), .DIM(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(wr), .Arow(arow),
    .Ain(ain), .Aout(aout), .done(done)
  );

  systolic_a_skew_feeder #(.BITS_AB(8), .DIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .WrEn(wr3), .Arow(arow3),
    .Ain(ain3), .Aout(aout3), .done(done3)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic        en;
    logic [1:0]  arow;
    logic [31:0] ain;
    logic [31:0] exp_aout;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic w, input logic e, input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    wr = w; en = e; arow = r; ain = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic w, input logic e, input logic [1:0] r, input logic [23:0] d);
    @(negedge clk);
    wr3 = w; en3 = e; arow3 = r; ain3 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic w, input logic e, input logic [1:0] r,
                     input logic [31:0] d, input logic [31:0] ea, input logic ed);
    vec_t v;
    v.name = n; v.wr = w; v.en = e; v.arow = r; v.ain = d; v.exp_aout = ea; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  initial begin
    // Tile mem[i][j] = 16*i+j+1; stream values hand-derived from lane i = mem[i][k-i].
    add("load0", 1, 0, 0, 32'h04030201, 32'h0, 0);
    add("load1", 1, 0, 1, 32'h14131211, 32'h0, 0);
    add("load2", 1, 0, 2, 32'h24232221, 32'h0, 0);
    add("load3", 1, 0, 3, 32'h34333231, 32'h0, 0);
    add("k0",    0, 1, 0, 32'h0, 32'h00000001, 0);
    add("k1",    0, 1, 0, 32'h0, 32'h00001102, 0);
    add("k2",    0, 1, 0, 32'h0, 32'h00211203, 0);
    add("k3",    0, 1, 0, 32'h0, 32'h31221304, 0);
    add("k4",    0, 1, 0, 32'h0, 32'h32231400, 0);
    add("k5",    0, 1, 0, 32'h0, 32'h33240000, 0);
    add("k6",    0, 1, 0, 32'h0, 32'h34000000, 1);
    add("sat",   0, 1, 0, 32'h0, 32'h00000000, 1);
    add("reld0", 1, 0, 0, 32'h04030201, 32'h0, 0);
    add("r_k0",  0, 1, 0, 32'h0, 32'h00000001, 0);
    add("r_k1",  0, 1, 0, 32'h0, 32'h00001102, 0);
    add("r_k2",  0, 1, 0, 32'h0, 32'h00211203, 0);
    for (int i = 0; i < 5; i++) add("idle", 0, 0, 0, 32'h0, 32'h00211203, 0);
    add("r_k3",  0, 1, 0, 32'h0, 32'h31221304, 0);
    add("wr_en", 1, 1, 2, 32'hFFFFFFFF, 32'h31221304, 0);
    add("w_k0",  0, 1, 0, 32'h0, 32'h00000001, 0);
    add("w_k1",  0, 1, 0, 32'h0, 32'h00001102, 0);
    add("w_k2",  0, 1, 0, 32'h0, 32'h00FF1203, 0);
    add("w_k3",  0, 1, 0, 32'h0, 32'h31FF1304, 0);

    rst_n = 1'b0;
    en = 0; wr = 0; arow = 0; ain = '0;
    en3 = 0; wr3 = 0; arow3 = 0; ain3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aout", aout, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      drive4(vecs[n].wr, vecs[n].en, vecs[n].arow, vecs[n].ain);
      chk({vecs[n].name, "_aout"}, aout, vecs[n].exp_aout);
      chk({vecs[n].name, "_done"}, {31'b0, done}, {31'b0, vecs[n].exp_done});
    end

    // Asynchronous reset mid-stream, away from any edge.
    drive4(0, 1, 0, 32'h0);
    chk("pre_rst_aout", aout, 32'h32FF1400);
    @(negedge clk);
    en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_aout", aout, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      drive4(0, 1, 0, 32'h0);
      chk($sformatf("post_rst_s%0d_aout", s), aout, 32'h0);
      chk($sformatf("post_rst_s%0d_done", s), {31'b0, done}, {31'b0, (s == 7)});
    end
    drive4(0, 0, 0, 32'h0);

    // DIM=3: row index 3 is out of range and must leave the tile untouched.
    drive3(1, 0, 0, 24'h030201);
    drive3(1, 0, 1, 24'h060504);
    drive3(1, 0, 2, 24'h090807);
    drive3(0, 1, 0, 24'h0);
    chk("d3_k0", {8'h0, aout3}, 32'h000001);
    drive3(0, 1, 0, 24'h0);
    chk("d3_k1", {8'h0, aout3}, 32'h000402);
    drive3(1, 0, 3, 24'hAAAAAA);
    chk("d3_oob_hold", {8'h0, aout3}, 32'h000402);
    chk("d3_oob_done", {31'b0, done3}, 32'h0);
    begin
      logic [23:0] exp3 [6];
      exp3[0] = 24'h000001; exp3[1] = 24'h000402; exp3[2] = 24'h070503;
      exp3[3] = 24'h080600; exp3[4] = 24'h090000; exp3[5] = 24'h000000;
      for (int s = 0; s < 6; s++) begin
        drive3(0, 1, 0, 24'h0);
        chk($sformatf("d3_r_k%0d_aout", s), {8'h0, aout3}, {8'h0, exp3[s]});
        chk($sformatf("d3_r_k%0d_done", s), {31'b0, done3}, {31'b0, (s >= 4)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
